// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM state,
// index-width helper and the rotate-priority search used by the selector.
package fifo_push_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Upper bound on requesters supported by the generic search below.
    localparam int unsigned MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_result_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask scanning upward from start, wrapping modulo n.
    function automatic rr_result_t rr_next(input logic [4:0]         start,
                                           input logic [MAX_REQ-1:0] mask,
                                           input int unsigned        n);
        rr_result_t r;
        logic [5:0] k;
        r = '0;
        for (int unsigned off = 0; off < MAX_REQ; off++) begin
            if (off < n && !r.found) begin
                k = {1'b0, start} + 6'(off);
                if (k >= 6'(n)) k = k - 6'(n);
                if (mask[k[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[4:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_select.sv
// Combinational rotate-priority search: lowest valid index at or above
// start, wrapping around the requester ring.
module fifo_rr_select
    import fifo_push_arbiter_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [MAX_REQ-1:0] mask;
    rr_result_t         r;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mask          = '0;
        mask[N-1:0]   = valid;
        r             = rr_next(5'(start), mask, N);
        found         = r.found;
        index         = IDX_W'(r.idx);
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several valid/ready
// producers, with bounded bursts and same-cycle release of an idle owner.
module fifo_push_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter int unsigned width                         = 8,
    parameter int unsigned n_requesters                  = 3,
    parameter int unsigned max_burst                     = 2,
    parameter bit          allow_push_when_full_with_pop = 1'b1,
    localparam int unsigned IDX_W = idx_width(n_requesters),
    localparam int unsigned CNT_W = $clog2(max_burst + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_requesters-1:0]       req_valid,
    input  logic [n_requesters*width-1:0] req_data,
    output logic [n_requesters-1:0]       req_ready,
    output logic                          push,
    output logic [width-1:0]              write_data,
    input  logic                          full,
    input  logic                          pop,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id
);

    state_e           st_q, st_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             can_push;
    logic             in_burst;
    logic             owner_hold;
    logic [IDX_W-1:0] sel_start;
    logic [n_requesters-1:0] sel_mask;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             raw_valid;
    logic [IDX_W-1:0] raw_id;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(n_requesters - 1)) ? '0 : x + 1'b1;
    endfunction

    // A released owner is excluded and the scan starts just past it.
    always_comb begin
        in_burst  = (st_q == BURST);
        sel_start = in_burst ? wrap_inc(owner_q) : wrap_inc(last_grant_q);
        sel_mask  = req_valid;
        if (in_burst) sel_mask[owner_q] = 1'b0;
    end

    fifo_rr_select #(
        .N     (n_requesters),
        .IDX_W (IDX_W)
    ) u_select (
        .valid (sel_mask),
        .start (sel_start),
        .found (sel_found),
        .index (sel_idx)
    );

    always_comb begin
        can_push   = ~full | (allow_push_when_full_with_pop & pop);
        owner_hold = in_burst & req_valid[owner_q];
        raw_valid  = owner_hold ? 1'b1    : sel_found;
        raw_id     = owner_hold ? owner_q : sel_idx;

        // Reset gates the handshake outputs combinationally so they drop immediately.
        grant_valid = rst & raw_valid;
        grant_id    = grant_valid ? raw_id : '0;
        push        = grant_valid & can_push;
        req_ready   = '0;
        if (push) req_ready[grant_id] = 1'b1;
        write_data  = req_data[int'(raw_id) * int'(width) +: width];

        st_d         = st_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        cnt_inc      = burst_cnt_q + 1'b1;

        if (owner_hold) begin
            if (push) begin
                if (cnt_inc == CNT_W'(max_burst)) begin
                    st_d         = IDLE;
                    last_grant_d = owner_q;
                    burst_cnt_d  = '0;
                end else begin
                    burst_cnt_d  = cnt_inc;
                end
            end
        end else begin
            if (in_burst) begin
                st_d         = IDLE;
                last_grant_d = owner_q;
                burst_cnt_d  = '0;
            end
            if (push) begin
                if (max_burst == 1) begin
                    st_d         = IDLE;
                    last_grant_d = raw_id;
                end else begin
                    st_d         = BURST;
                    owner_d      = raw_id;
                    burst_cnt_d  = CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(n_requesters - 1);
            burst_cnt_q  <= '0;
        end else begin
            st_q         <= st_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the write port of one flip_flop_fifo_with_counter among n_requesters producers.
- Each producer uses a valid/ready interface. The arbiter drives the FIFO's push and write_data.
- Grants are bounded bursts: an owner keeps the port for up to max_burst consecutive beats, then ownership rotates.
- Sits directly in front of the FIFO write side and observes full and pop.

Parameters:
- width, 8, data width; must match the FIFO.
- n_requesters, 3, number of producers; at least 2.
- max_burst, 2, maximum consecutive beats per grant; at least 1.
- allow_push_when_full_with_pop, 1, permits a push while full if the FIFO pops in the same cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  n_requesters  per-producer data valid.
- req_data  input  n_requesters*width  packed producer data; requester i occupies bits [i*width +: width].
- req_ready  output  n_requesters  per-producer accept; one-hot or zero.
- push  output  1  FIFO push.
- write_data  output  width  FIFO write data.
- full  input  1  FIFO full.
- pop  input  1  FIFO pop in the current cycle.
- grant_valid  output  1  a requester is granted this cycle.
- grant_id  output  $clog2(n_requesters)  index of the granted requester; 0 when grant_valid=0.

Behaviour:
- can_push = ~full | (allow_push_when_full_with_pop & pop).
- Grant and accept are combinational from the registered state and the inputs: zero-cycle latency.
- Transfer for requester i = req_valid[i] & req_ready[i].
- push = grant_valid & can_push.
- write_data = req_data slice of grant_id; don't-care when push=0.
- req_ready[grant_id] = can_push; all other req_ready bits are 0.
- Registered state: st (IDLE, BURST), owner, last_grant, burst_cnt (width $clog2(max_burst+1)).
- Reset (rst=0, asynchronous): st=IDLE, owner=0, last_grant=n_requesters-1, burst_cnt=0.
- While rst=0, push=0, req_ready=0 and grant_valid=0, regardless of other inputs.
- Round-robin select: the first valid requester scanning from last_grant+1 upward, wrapping modulo n_requesters.
- IDLE:
  - Grant = round-robin select; grant_valid = |req_valid.
  - On a transfer from requester i with max_burst=1: stay IDLE, last_grant=i.
  - On a transfer from requester i with max_burst>1: go to BURST, owner=i, burst_cnt=1.
  - No transfer (nothing valid, or can_push=0): state unchanged.
- BURST, owner valid:
  - Grant = owner.
  - On a transfer: burst_cnt+1. If the new count equals max_burst, go to IDLE, last_grant=owner, burst_cnt=0.
  - can_push=0: hold all state; no count change.
- BURST, owner not valid:
  - Ownership is released the same cycle; no bubble cycle.
  - Grant falls to round-robin select starting at owner+1, with the owner excluded.
  - last_grant=owner.
  - Next state is computed as in IDLE for that grant: a transfer starts a new BURST, or stays IDLE when max_burst=1; otherwise go to IDLE.
- Producers must hold req_data stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- The arbiter never pushes when can_push=0. FIFO overflow is impossible by construction.
- Releasing rst mid-burst resumes from the reset state: the first grant goes to the lowest-index valid requester.

Decomposition:
- Package fifo_push_arbiter_pkg:
  - state enum (IDLE, BURST);
  - localparam helper for index width;
  - function rr_next (start index, valid mask) returning found flag and index.
- One combinational sub-module, fifo_rr_select:
  - inputs: valid mask, start pointer;
  - outputs: found, index;
  - rotate-priority search.
- The top level holds the FSM, the counters and the data mux.

Test Plan:
Common setup: width=8, n_requesters=3, max_burst=2, FIFO depth=5.
1. All three valid continuously; FIFO pops every cycle. Data: req0 0x00,0x01..., req1 0x10..., req2 0x20... -> grant_id sequence 0,0,1,1,2,2,0,0; push=1 every cycle; the FIFO read stream equals the grant order.
2. Only req1 valid with 0x11,0x12,0x13,0x14 -> push on 4 consecutive cycles, grant_id=1 throughout (burst release re-selects 1), no idle cycle.
3. All valid, no pop, until full (5 entries) -> push=0, req_ready=0, burst_cnt and last_grant frozen. Then pop=1 with full=1 -> push=1 in the same cycle with the correct owner's data.
4. req0 sends 0xA0, then drops valid after one beat of its burst while req2 is valid with 0xC0 -> the next cycle grant_id=2 and 0xC0 is pushed, no bubble; req1 (invalid) is skipped.
5. rst driven low while in BURST with owner=1, burst_cnt=1 -> push=0 and req_ready=0 immediately (asynchronous). After release with all valid, the first grant goes to 0.
6. Parameter set allow_push_when_full_with_pop=0: full=1 with pop=1 and all requesters valid -> push=0, req_ready=0.
